// File: rtl/axil_pkg.sv
// Shared AXI4-Lite definitions: response codes, default protection value and
// a helper that maps a decode error onto the response code.
package axil_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } axil_resp_t;

    localparam logic [2:0] AXIL_PROT_DEFAULT = 3'b000;

    function automatic axil_resp_t axil_resp(input logic i_err);
        return i_err ? SLVERR : OKAY;
    endfunction

endpackage

// File: rtl/axil_mem_bank.sv
// 1W/1R synchronous RAM, one byte lane per generate iteration, registered read.
// A same-edge read and write to one word returns the old contents.
module axil_mem_bank #(
    parameter int STRB_WIDTH = 8,
    parameter int DEPTH      = 1024,
    parameter int IDX_W      = 10
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        i_we,
    input  logic [STRB_WIDTH-1:0]       i_wbe,
    input  logic [IDX_W-1:0]            i_waddr,
    input  logic [STRB_WIDTH-1:0][7:0]  i_wdata,
    input  logic                        i_re,
    input  logic [IDX_W-1:0]            i_raddr,
    output logic [STRB_WIDTH-1:0][7:0]  o_rdata
);

    for (genvar b = 0; b < STRB_WIDTH; b++) begin : g_lane
        logic [7:0] r_mem [DEPTH];
        logic [7:0] r_q;

        // Storage is deliberately not reset so contents survive anreset.
        always_ff @(posedge clk) begin
            if (i_we && i_wbe[b])
                r_mem[i_waddr] <= i_wdata[b];
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                r_q <= '0;
            else if (i_re)
                r_q <= r_mem[i_raddr];
        end

        assign o_rdata[b] = r_q;
    end

endmodule

// File: rtl/axil_mem_slave.sv
// AXI4-Lite memory subordinate: AW/W holding registers, B/R response registers,
// address decode. Define AXIL_MEM_SLAVE_RANGE_CHECK_EN for SLVERR on out-of-range.
module axil_mem_slave
    import axil_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 16,
    parameter int                    DATA_WIDTH = 64,
    parameter int                    STRB_WIDTH = DATA_WIDTH / 8,
    parameter int                    MEM_DEPTH  = 1024,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                    aclk,
    input  logic                    anreset,
    input  logic                    aenable,
    input  logic [ADDR_WIDTH-1:0]   i_awaddr,
    input  logic [2:0]              i_awprot,
    input  logic                    i_awvalid,
    output logic                    o_awready,
    input  logic [DATA_WIDTH-1:0]   i_wdata,
    input  logic [STRB_WIDTH-1:0]   i_wstrb,
    input  logic                    i_wvalid,
    output logic                    o_wready,
    output logic [1:0]              o_bresp,
    output logic                    o_bvalid,
    input  logic                    i_bready,
    input  logic [ADDR_WIDTH-1:0]   i_araddr,
    input  logic [2:0]              i_arprot,
    input  logic                    i_arvalid,
    output logic                    o_arready,
    output logic [DATA_WIDTH-1:0]   o_rdata,
    output logic [1:0]              o_rresp,
    output logic                    o_rvalid,
    input  logic                    i_rready
);

    localparam int OFF_W = $clog2(STRB_WIDTH);
    localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    logic                   r_aw_held, r_w_held;
    logic [ADDR_WIDTH-1:0]  r_awaddr;
    logic [DATA_WIDTH-1:0]  r_wdata;
    logic [STRB_WIDTH-1:0]  r_wstrb;
    logic                   r_bvalid, r_rvalid, r_rzero;
    axil_resp_t             r_bresp, r_rresp;

    logic                   w_aw_hs, w_w_hs, w_ar_hs, w_commit;
    logic [ADDR_WIDTH-1:0]  w_aw_word, w_ar_word;
    logic                   w_aw_oor, w_ar_oor;
    logic [DATA_WIDTH-1:0]  w_bank_q;
    logic                   w_unused;

    assign o_awready = aenable & ~r_aw_held;
    assign o_wready  = aenable & ~r_w_held;
    assign o_arready = aenable & ~r_rvalid;

    assign w_aw_hs  = i_awvalid & o_awready;
    assign w_w_hs   = i_wvalid  & o_wready;
    assign w_ar_hs  = i_arvalid & o_arready;
    assign w_commit = r_aw_held & r_w_held & ~r_bvalid;

    assign w_aw_word = (r_awaddr - BASE_ADDR) >> OFF_W;
    assign w_ar_word = (i_araddr - BASE_ADDR) >> OFF_W;

`ifdef AXIL_MEM_SLAVE_RANGE_CHECK_EN
    assign w_aw_oor = (r_awaddr < BASE_ADDR) || (32'(w_aw_word) >= 32'(MEM_DEPTH));
    assign w_ar_oor = (i_araddr < BASE_ADDR) || (32'(w_ar_word) >= 32'(MEM_DEPTH));
`else
    // Word index wraps modulo MEM_DEPTH; every access is in range.
    assign w_aw_oor = 1'b0;
    assign w_ar_oor = 1'b0;
`endif

    // Protection bits and the address bits above the word index carry no meaning here.
    assign w_unused = ^{i_awprot, i_arprot, w_aw_word, w_ar_word};

    always_ff @(posedge aclk or negedge anreset) begin
        if (!anreset) begin
            r_aw_held <= 1'b0;
            r_awaddr  <= '0;
            r_w_held  <= 1'b0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_bvalid  <= 1'b0;
            r_bresp   <= OKAY;
        end else begin
            if (w_aw_hs) begin
                r_aw_held <= 1'b1;
                r_awaddr  <= i_awaddr;
            end
            if (w_w_hs) begin
                r_w_held <= 1'b1;
                r_wdata  <= i_wdata;
                r_wstrb  <= i_wstrb;
            end
            // A handshake cannot coincide with commit: commit needs both holds set.
            if (w_commit) begin
                r_aw_held <= 1'b0;
                r_w_held  <= 1'b0;
                r_bvalid  <= 1'b1;
                r_bresp   <= axil_resp(w_aw_oor);
            end else if (r_bvalid && i_bready) begin
                r_bvalid <= 1'b0;
            end
        end
    end

    always_ff @(posedge aclk or negedge anreset) begin
        if (!anreset) begin
            r_rvalid <= 1'b0;
            r_rresp  <= OKAY;
            r_rzero  <= 1'b0;
        end else if (w_ar_hs) begin
            r_rvalid <= 1'b1;
            r_rresp  <= axil_resp(w_ar_oor);
            r_rzero  <= w_ar_oor;
        end else if (r_rvalid && i_rready) begin
            r_rvalid <= 1'b0;
        end
    end

    // Bank read register only loads on AR handshake, so rdata holds while rvalid.
    axil_mem_bank #(
        .STRB_WIDTH (STRB_WIDTH),
        .DEPTH      (MEM_DEPTH),
        .IDX_W      (IDX_W)
    ) u_bank (
        .clk     (aclk),
        .rst_n   (anreset),
        .i_we    (w_commit & ~w_aw_oor),
        .i_wbe   (r_wstrb),
        .i_waddr (w_aw_word[IDX_W-1:0]),
        .i_wdata (r_wdata),
        .i_re    (w_ar_hs),
        .i_raddr (w_ar_word[IDX_W-1:0]),
        .o_rdata (w_bank_q)
    );

    assign o_bvalid = r_bvalid;
    assign o_bresp  = r_bresp;
    assign o_rvalid = r_rvalid;
    assign o_rresp  = r_rresp;
    assign o_rdata  = r_rzero ? '0 : w_bank_q;

endmodule
